shift_deser: RTL and testbench
==============================

Name: shift_deser

Overview:
Serial-in, parallel-out receiver: the inverse of the parallel shift unit. It accepts one bit per qualified cycle, shifts each bit into an internal register in a selectable direction, and presents each completed WIDTH-bit word on a double-buffered output with a valid/ready handshake. It sits at the receiving end of the shift datapath and rebuilds bytes that were serialised LSB-first or MSB-first.

Parameters:
WIDTH, 8, word width in bits; must be 2 or more.
CNT_W, 3, bit-counter width; equals ceil(log2(WIDTH)).

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  reset; synchronous, active-low.
sin  input  1  serial data bit.
sin_valid  input  1  sin is sampled on this cycle.
dir  input  1  0 = right shift-in (bit enters at MSB, first bit ends at LSB, LSB-first stream); 1 = left shift-in (bit enters at LSB, first bit ends at MSB, MSB-first stream).
clear  input  1  synchronous soft clear of the partial word and the overrun flag.
out  output  WIDTH  completed word.
out_valid  output  1  out holds an unconsumed word.
out_ready  input  1  consumer accepts out this cycle when out_valid is 1.
overrun  output  1  sticky: a completed word was dropped.
busy  output  1  a partial word is in progress (bit count is not 0).

Behaviour:
- Reset (rst=0 at a clock edge): shift register 0, bit count 0, state IDLE, out=0, out_valid=0, overrun=0, busy=0. Reset has priority over every other input. A reset mid-word discards the partial word.
- clear=1 (rst=1): bit count 0, shift register 0, overrun=0, state IDLE. The held word and out_valid are unchanged. The sin bit on that cycle is ignored.
- FSM states:
  - IDLE: bit count is 0. On sin_valid, go to COLLECT.
  - COLLECT: 0 < count < WIDTH.
  - On the WIDTH-th bit, go to IDLE and commit the word.
- dir is latched on the first bit of each word. Changes of dir mid-word are ignored until the next word.
- Shift rules:
  - dir=0: sreg <= {sin, sreg[WIDTH-1:1]}.
  - dir=1: sreg <= {sreg[WIDTH-2:0], sin}.
- Commit: the completed word is the shift result that includes the final bit. It is written to out in the same clock edge, so out_valid rises the cycle after the last bit is sampled (latency 1).
- sin_valid=0 cycles are gaps; state and count hold. There is no timeout.
- Handshake: out and out_valid stay stable while out_valid=1 and out_ready=0. A transfer occurs when out_valid and out_ready are both 1 at an edge. out_valid then falls unless a new word commits on that same edge.
- Commit while the holding register is free, or is being consumed this cycle: load out, out_valid=1, no overrun.
- Commit while out_valid=1 and out_ready=0: the new word is dropped, out is unchanged, and overrun is set to 1. overrun stays 1 until clear or reset.
- The shift register keeps collecting the next word while out is held (double buffering). The sustained rate is 1 bit per cycle with no bubbles.
- clear and commit on the same cycle: clear wins and nothing commits.
- busy = (count != 0), registered together with count.

Decomposition:
- Shared package (shift_pkg):
  - DIR_LSB_FIRST = 1'b0, DIR_MSB_FIRST = 1'b1.
  - FSM state encoding: IDLE = 1'b0, COLLECT = 1'b1.
  - The same op encodings already used by the parallel shift unit, kept alongside for reuse.
- One natural sub-module: shift_deser_hold, the output holding register with valid/ready and overrun detection. It has inputs commit, word, and out_ready.
- The shifter, counter and FSM stay in the top module.

Test Plan:
- dir=0, send 1,0,1,0,0,1,0,1 on consecutive cycles with out_ready=1 -> out=0xA5 and out_valid=1 one cycle after the 8th bit, for exactly one cycle.
- dir=1, send 0x3C MSB-first (0,0,1,1,1,1,0,0) with one sin_valid=0 gap after bit 3 -> out=0x3C, busy=1 during the gap.
- out_ready=0, send 0x11 then 0x22 (dir=0) back-to-back -> out stays 0x11, overrun=1 on the edge where 0x22 completes. Then raise out_ready -> 0x11 transfers, out_valid=0, overrun stays 1 until a clear pulse.
- Send 4 bits of 0xFF, pull rst=0 for one cycle, then send 0x5A (dir=0) -> out=0x5A, with no residue from the aborted bits.
- Send 5 bits, pulse clear, then send 0x81 with dir toggled after bit 2 -> out=0x81 decoded with the dir latched at bit 0.
- Consume word 0x12 with out_ready=1 on the same edge that word 0x34 commits -> 0x12 is accepted, out=0x34, out_valid stays 1, overrun=0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift datapath: stream direction, deserialiser
// FSM encoding and the parallel shift unit's op codes.
package shift_pkg;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // Op codes of the parallel shift unit, shared so both ends agree.
  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } shift_op_e;

endpackage

// File: rtl/shift_deser_hold.sv
// Output holding register: one-word buffer with valid/ready and a sticky
// overrun flag for words that arrive while the buffer is still occupied.
module shift_deser_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             commit,
  input  logic [WIDTH-1:0] word,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             slot_free;

  // The slot can accept a word when empty or when it empties on this edge.
  assign slot_free = !valid_q || out_ready;

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (commit && slot_free) begin
      out_d   = word;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (clear) begin
      ovr_d = 1'b0;
    end else if (commit && !slot_free) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

endmodule

// File: rtl/shift_deser.sv
// Serial-in, parallel-out receiver. Bits shift in LSB-first or MSB-first
// (direction latched on each word's first bit); finished words go to a
// one-deep holding register so collection continues while a word waits.
//
// Handshake: out is offered while out_valid=1 and stays stable until a
// rising edge sees out_valid=1 and out_ready=1, which is the transfer.
module shift_deser
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             dir,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             busy,
  output state_e           dbg_state
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             dir_q, dir_d;
  logic             busy_q;
  logic             eff_dir;
  logic             last_bit;
  logic             commit;
  logic [WIDTH-1:0] shifted;

  // The live dir input only matters on a word's first bit.
  assign eff_dir  = (state_q == IDLE) ? dir : dir_q;
  assign shifted  = (eff_dir == DIR_MSB_FIRST) ? {sreg_q[WIDTH-2:0], sin}
                                               : {sin, sreg_q[WIDTH-1:1]};
  assign last_bit = (count_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sreg_d  = sreg_q;
    dir_d   = dir_q;
    commit  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
      sreg_d  = '0;
    end else if (sin_valid) begin
      sreg_d = shifted;
      dir_d  = eff_dir;
      case (state_q)
        IDLE: begin
          state_d = COLLECT;
          count_d = CNT_W'(1);
        end
        COLLECT: begin
          if (last_bit) begin
            state_d = IDLE;
            count_d = '0;
            commit  = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      sreg_q  <= '0;
      dir_q   <= DIR_LSB_FIRST;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sreg_q  <= sreg_d;
      dir_q   <= dir_d;
      busy_q  <= (count_d != '0);
    end
  end

  shift_deser_hold #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .commit    (commit),
    .word      (shifted),
    .out_ready (out_ready),
    .out       (out),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_deser.sv
// Bench for shift_deser: directed scenarios plus random traffic, checked by a
// bit-list reference model feeding an expected-word queue.
module tb_shift_deser;
  import shift_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         dir = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         overrun;
  logic         busy;
  state_e       dbg_state;

  shift_deser #(.WIDTH(W), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_valid (sin_valid),
    .dir       (dir),
    .clear     (clear),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  // Reference model: bits received so far, direction of the current word,
  // occupancy of the output slot and the sticky overrun flag.
  logic         bits_q[$];
  logic         m_dir     = 1'b0;
  logic         m_valid   = 1'b0;
  logic         m_overrun = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] assemble(input logic d);
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) begin
      if (d == 1'b0) w[i] = bits_q[i];
      else           w[W-1-i] = bits_q[i];
    end
    return w;
  endfunction

  task automatic model_edge(input logic rn, input logic cl, input logic v,
                            input logic s, input logic d, input logic r);
    logic         done = 1'b0;
    logic [W-1:0] w = '0;
    if (!rn) begin
      bits_q.delete();
      exp_q.delete();
      m_valid   = 1'b0;
      m_overrun = 1'b0;
    end else begin
      if (cl) begin
        bits_q.delete();
        m_overrun = 1'b0;
      end else if (v) begin
        if (bits_q.size() == 0) m_dir = d;
        bits_q.push_back(s);
        if (bits_q.size() == W) begin
          w    = assemble(m_dir);
          done = 1'b1;
          bits_q.delete();
        end
      end
      if (done) begin
        if (!m_valid || r) begin
          exp_q.push_back(w);
          m_valid = 1'b1;
        end else begin
          m_overrun = 1'b1;
        end
      end else if (m_valid && r) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic step(input logic rn, input logic cl, input logic v,
                      input logic s, input logic d, input logic r);
    rst = rn; clear = cl; sin_valid = v; sin = s; dir = d; out_ready = r;
    @(posedge clk);
    model_edge(rn, cl, v, s, d, r);
    #1;
  endtask

  // Sends one word; gap_at inserts an idle cycle after that bit index,
  // toggle_at flips the driven dir after that bit index.
  task automatic send_word(input logic [W-1:0] w, input logic d, input int gap_at,
                           input int toggle_at, input logic r, input logic r_last);
    logic dd = d;
    for (int i = 0; i < W; i++) begin
      step(1'b1, 1'b0, 1'b1, (d == 1'b0) ? w[i] : w[W-1-i], dd,
           (i == W-1) ? r_last : r);
      if (i == gap_at) step(1'b1, 1'b0, 1'b0, 1'b0, dd, r);
      if (i == toggle_at) dd = ~dd;
    end
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, r);
  endtask

  // Monitor: compares status every cycle and the held word against the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("overrun", {31'd0, overrun}, {31'd0, m_overrun});
      chk("busy", {31'd0, busy}, {31'd0, bits_q.size() != 0});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {24'd0, out}, 32'hFFFF_FFFF);
        end else begin
          chk("out_word", {24'd0, out}, {24'd0, exp_q[0]});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_out", {24'd0, out}, 32'h0);
    chk("reset_state", {31'd0, dbg_state}, {31'd0, IDLE});
    mon_en = 1'b1;

    // LSB-first 0xA5, consumer always ready.
    send_word(8'hA5, DIR_LSB_FIRST, -1, -1, 1'b1, 1'b1);
    chk("a5_word", {24'd0, out}, 32'hA5);
    idle(2, 1'b1);

    // MSB-first 0x3C with a gap after bit 3.
    send_word(8'h3C, DIR_MSB_FIRST, 3, -1, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Overrun: 0x11 held, 0x22 dropped, overrun sticky until clear.
    send_word(8'h11, DIR_LSB_FIRST, -1, -1, 1'b0, 1'b0);
    send_word(8'h22, DIR_LSB_FIRST, -1, -1, 1'b0, 1'b0);
    chk("ovr_held", {24'd0, out}, 32'h11);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    idle(3, 1'b1);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);

    // Reset mid-word, then 0x5A.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'h5A, DIR_LSB_FIRST, -1, -1, 1'b1, 1'b1);
    chk("after_reset_word", {24'd0, out}, 32'h5A);
    idle(2, 1'b1);

    // Clear mid-word, then 0x81 with dir toggled after bit 2.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    send_word(8'h81, DIR_LSB_FIRST, -1, 2, 1'b1, 1'b1);
    chk("after_clear_word", {24'd0, out}, 32'h81);
    idle(2, 1'b1);

    // 0x12 consumed on the same edge that 0x34 commits.
    send_word(8'h12, DIR_MSB_FIRST, -1, -1, 1'b0, 1'b0);
    send_word(8'h34, DIR_MSB_FIRST, -1, -1, 1'b0, 1'b1);
    chk("swap_word", {24'd0, out}, 32'h34);
    chk("swap_ovr", {31'd0, overrun}, 32'd0);
    idle(2, 1'b1);

    // Random traffic with gaps, stalls, dir changes and occasional clears.
    for (int i = 0; i < 1500; i++) begin
      step(1'b1, $urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) != 0);
    end
    idle(4, 1'b1);
    chk("drained", exp_q.size(), 32'd0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
